// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the countdown timer and the game-control FSM:
// state encoding, state width and the prescaler width helper.
// -----------------------------------------------------------------------------
package timer_pkg;

   // Width of the encoded timer state.
   localparam int unsigned STATE_W = 2;

   // Timer state encoding; the game-control FSM decodes these same values.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } timer_state_e;

   // Prescaler counter width: max(1, clog2(prescale)).
   function automatic int unsigned presc_width(input int unsigned prescale);
      int unsigned w;
      w = (prescale > 1) ? int'($clog2(prescale)) : 1;
      return w;
   endfunction

endpackage : timer_pkg

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running rate divider: while enabled, emits a one-cycle tick on every
// PRESCALE-th enabled cycle. Holding en low freezes the phase so a paused
// client resumes mid-period.
//
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset (phase -> 0)
//   en    in  advance the phase this cycle
//   clr   in  force the phase back to 0 (wins over en, suppresses tick)
//   tick  out high in the cycle whose edge completes a period
// -----------------------------------------------------------------------------
module tick_prescaler
   import timer_pkg::*;
#(
   parameter int unsigned PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned      CNT_W = presc_width(PRESCALE);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             wrap_c;

   // Last phase of the period: the next enabled edge completes a step.
   assign wrap_c = (cnt_q == LAST);

   // Tick is qualified with en so the consumer can act on it at the same edge.
   assign tick = en & ~clr & wrap_c;

   // Phase next-state.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // Phase register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : tick_prescaler

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Loadable, pausable down-counter with prescaler and optional auto-reload.
// Counts from the loaded value to zero, then flags expiry with a one-cycle
// done_pulse and a level expired. Drives round/step timeouts.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   load         in   capture load_val into count and reload register, go IDLE
//   load_val     in   [WIDTH] value to count down from
//   start        in   begin/resume counting, or restart after expiry
//   pause        in   freeze counting while running
//   auto_reload  in   on expiry reload and keep running
//   count        out  [WIDTH] current count
//   busy         out  high while running
//   expired      out  high once expired
//   done_pulse   out  one-cycle marker of every expiry event
// -----------------------------------------------------------------------------
module countdown_timer
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             expired,
   output logic             done_pulse
);

   timer_state_e     state_q;
   timer_state_e     state_d;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] reload_q;
   logic [WIDTH-1:0] reload_d;
   logic             done_q;
   logic             done_d;

   logic             presc_en_c;
   logic             presc_clr_c;
   logic             tick_c;

   // Step-rate divider; only advances on edges where the timer really counts.
   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (presc_en_c),
      .clr  (presc_clr_c),
      .tick (tick_c)
   );

   // Next-state, count/reload and done logic.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      reload_d    = reload_q;
      done_d      = 1'b0;
      presc_en_c  = 1'b0;
      presc_clr_c = 1'b0;

      if (load) begin
         // Load overrides everything, including an expiry due this edge.
         count_d     = load_val;
         reload_d    = load_val;
         presc_clr_c = 1'b1;
         state_d     = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_PAUSED: begin
               // Prescaler kept as-is so a resume continues mid-step.
               if (start) begin
                  if (count_q != '0) begin
                     state_d = ST_RUN;
                  end else begin
                     state_d = ST_EXPIRED;
                     done_d  = 1'b1;
                  end
               end
            end

            ST_RUN: begin
               if (pause) begin
                  // Pause edge holds both count and prescaler phase.
                  state_d = ST_PAUSED;
               end else begin
                  presc_en_c = 1'b1;
                  if (tick_c) begin
                     if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                     end else begin
                        done_d = 1'b1;
                        if (auto_reload && (reload_q != '0)) begin
                           // Prescaler wraps to 0 this edge: no dead cycle.
                           count_d = reload_q;
                        end else begin
                           count_d = '0;
                           state_d = ST_EXPIRED;
                        end
                     end
                  end
               end
            end

            ST_EXPIRED: begin
               if (start && (reload_q != '0)) begin
                  count_d     = reload_q;
                  presc_clr_c = 1'b1;
                  state_d     = ST_RUN;
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, count, reload and done registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   assign count      = count_q;
   assign busy       = (state_q == ST_RUN);
   assign expired    = (state_q == ST_EXPIRED);
   assign done_pulse = done_q;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
// Two timers (PRESCALE 4 and 1) share one stimulus stream. The reference
// model tracks, per timer, the number of counting edges remaining until
// expiry; the visible count is that figure divided by PRESCALE, rounded up.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst;
   logic         load;
   logic [W-1:0] load_val;
   logic         start;
   logic         pause;
   logic         auto_reload;

   logic [W-1:0] c4, c1;
   logic         b4, e4, d4, b1, e1, d1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state, index 0 -> PRESCALE 4, index 1 -> PRESCALE 1.
   int m_p    [2] = '{4, 1};
   int m_rem  [2] = '{0, 0};   // counting edges left until expiry
   int m_rl   [2] = '{0, 0};   // reload value
   bit m_run  [2] = '{0, 0};
   bit m_exp  [2] = '{0, 0};
   bit m_done [2] = '{0, 0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   countdown_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
      .pause(pause), .auto_reload(auto_reload), .count(c4), .busy(b4),
      .expired(e4), .done_pulse(d4)
   );

   countdown_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
      .pause(pause), .auto_reload(auto_reload), .count(c1), .busy(b1),
      .expired(e1), .done_pulse(d1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Apply one clock edge's worth of the timer rules to model i.
   task automatic model_edge(input int i);
      m_done[i] = 1'b0;
      if (rst) begin
         m_rem[i] = 0; m_rl[i] = 0; m_run[i] = 1'b0; m_exp[i] = 1'b0;
      end else if (load) begin
         m_rem[i] = int'(load_val) * m_p[i];
         m_rl[i]  = int'(load_val);
         m_run[i] = 1'b0; m_exp[i] = 1'b0;
      end else if (m_run[i]) begin
         if (!pause) begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin
               m_done[i] = 1'b1;
               if (auto_reload && m_rl[i] != 0) begin
                  m_rem[i] = m_rl[i] * m_p[i];
               end else begin
                  m_run[i] = 1'b0; m_exp[i] = 1'b1;
               end
            end
         end else begin
            m_run[i] = 1'b0;
         end
      end else if (m_exp[i]) begin
         if (start && m_rl[i] != 0) begin
            m_rem[i] = m_rl[i] * m_p[i];
            m_run[i] = 1'b1; m_exp[i] = 1'b0;
         end
      end else if (start) begin
         if (m_rem[i] == 0) begin
            m_exp[i] = 1'b1; m_done[i] = 1'b1;
         end else begin
            m_run[i] = 1'b1;
         end
      end
   endtask

   function automatic int exp_count(input int i);
      return (m_rem[i] + m_p[i] - 1) / m_p[i];
   endfunction

   task automatic compare_all();
      check("count_p4",   32'(c4), exp_count(0));
      check("busy_p4",    32'(b4), 32'(m_run[0]));
      check("expired_p4", 32'(e4), 32'(m_exp[0]));
      check("done_p4",    32'(d4), 32'(m_done[0]));
      check("count_p1",   32'(c1), exp_count(1));
      check("busy_p1",    32'(b1), 32'(m_run[1]));
      check("expired_p1", 32'(e1), 32'(m_exp[1]));
      check("done_p1",    32'(d1), 32'(m_done[1]));
   endtask

   // One clock edge: update models with the sampled inputs, then compare.
   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      cyc++;
      compare_all();
   endtask

   task automatic idle_inputs();
      rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; load_val = '0;
   endtask

   // Bounded wait for the PRESCALE-4 timer's done_pulse; -1 on timeout.
   task automatic wait_done4(input int max_cycles, output int at);
      int n;
      at = -1;
      n  = 0;
      while (at < 0 && n < max_cycles) begin
         step();
         n++;
         if (d4 === 1'b1) at = cyc;
      end
   endtask

   initial begin
      int e0, at, nd, ne;

      rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
      auto_reload = 1'b0; load_val = '0;

      // Reset then idle.
      step(); step();
      rst = 1'b0;
      repeat (50) step();
      check("idle_count", 32'(c4), 0);

      // Basic countdown: load 3, done 12 edges after start.
      load = 1'b1; load_val = 8'd3; step();
      idle_inputs(); start = 1'b1; step(); e0 = cyc; start = 1'b0;
      wait_done4(20, at);
      check("basic_done_at", at - e0, 12);
      repeat (3) step();
      check("basic_expired_hold", 32'(e4), 1);

      // Pause/resume: 7 non-counting edges delay expiry by 7.
      load = 1'b1; load_val = 8'd5; step();
      idle_inputs(); start = 1'b1; step(); e0 = cyc; start = 1'b0;
      repeat (5) step();
      pause = 1'b1;
      repeat (6) step();
      start = 1'b1; step();
      idle_inputs();
      wait_done4(40, at);
      check("pause_done_at", at - e0, 27);

      // Auto-reload period on the PRESCALE-1 timer.
      auto_reload = 1'b1;
      load = 1'b1; load_val = 8'd2; step();
      idle_inputs(); start = 1'b1; step(); start = 1'b0;
      nd = 0; ne = 0;
      repeat (12) begin
         step();
         if (d1 === 1'b1) nd++;
         if (e1 === 1'b1) ne++;
      end
      check("ar_pulses", nd, 6);
      check("ar_never_expired", ne, 0);
      auto_reload = 1'b0;
      repeat (4) step();
      check("ar_off_expired", 32'(e1), 1);

      // Zero load, ignored restart, then load+start priority.
      load = 1'b1; load_val = 8'd0; step();
      idle_inputs(); start = 1'b1; step();
      check("zero_done", 32'(d4), 1);
      check("zero_expired", 32'(e4), 1);
      start = 1'b0; step();
      start = 1'b1; step();
      check("zero_restart_ignored", 32'(b4), 0);
      load = 1'b1; load_val = 8'h5A; step();
      idle_inputs();
      check("load_start_count", 32'(c4), 90);
      check("load_start_idle", 32'(b4 | e4), 0);

      // Load on the expiry edge wins over done_pulse.
      load = 1'b1; load_val = 8'd2; step();
      idle_inputs(); start = 1'b1; step(); start = 1'b0;
      repeat (7) step();
      load = 1'b1; load_val = 8'd7; step();
      idle_inputs();
      check("load_beats_done", 32'(d4), 0);
      check("load_beats_count", 32'(c4), 7);

      // Reset at step 4 of a run.
      load = 1'b1; load_val = 8'd9; step();
      idle_inputs(); start = 1'b1; step(); start = 1'b0;
      repeat (15) step();
      rst = 1'b1; step(); rst = 1'b0;
      nd = 0;
      repeat (40) begin
         step();
         if ((d4 | d1) === 1'b1) nd++;
      end
      check("rst_no_done", nd, 0);
      check("rst_count", 32'(c4), 0);

      // Randomized traffic against the model.
      repeat (1500) begin
         rst      = ($urandom_range(0, 99) == 0);
         load     = ($urandom_range(0, 15) == 0);
         load_val = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2))
                                                : 8'($urandom_range(0, 20));
         start    = ($urandom_range(0, 5) == 0);
         pause    = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 31) == 0) auto_reload = ~auto_reload;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_countdown_timer
